// File: rtl/guess_entry_if.sv
// ---------------------------------------------------------------------------
// guess_entry_if
// Guess hand-off channel between the guess-entry stage and the scorer.
//   valid : a committed guess is being offered (driven by the entry stage)
//   ready : the scorer takes the guess this cycle (driven by the scorer)
//   data  : packed guess, slot i at [i*COLOR_W +: COLOR_W]
// Modports: master = entry stage, slave = scorer.
// ---------------------------------------------------------------------------
interface guess_entry_if #(
  parameter int W = 12
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/guess_entry.sv
// ---------------------------------------------------------------------------
// guess_entry
// Player guess-entry stage for the colour-code game. NUM_SLOTS colour slots
// are edited with single-cycle left/right/up/down pulses. A submit snapshots
// the slots into a packed guess that is offered to the scorer over a
// valid/ready channel. Accepted guesses are counted, and once MAX_GUESSES
// have been accepted further submits are refused (editing stays possible).
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   enable_i        qualifies left/right/up/down/submit/clear
//   left_i/right_i  select previous/next slot (modulo NUM_SLOTS)
//   up_i/down_i     selected slot colour +1 / -1 (wrap or saturate)
//   submit_i        commit current slots as a guess
//   clear_i         zero all slots and selection
//   gbus            guess channel (master side: valid/data out, ready in)
//   slots_o         live slot colours for display, same packing as guess
//   sel_led_o       currently selected slot
//   guess_count_o   number of accepted guesses
//   exhausted_o     guess_count_o == MAX_GUESSES
// ---------------------------------------------------------------------------
module guess_entry #(
  parameter int NUM_SLOTS       = 4,
  parameter int COLOR_W         = 3,
  parameter int NUM_COLORS      = 8,
  parameter int SEL_W           = 2,
  parameter int WRAP            = 1,
  parameter int CLEAR_ON_ACCEPT = 0,
  parameter int MAX_GUESSES     = 10,
  parameter int CNT_W           = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable_i,
  input  logic                         left_i,
  input  logic                         right_i,
  input  logic                         up_i,
  input  logic                         down_i,
  input  logic                         submit_i,
  input  logic                         clear_i,
  guess_entry_if.master                gbus,
  output logic [NUM_SLOTS*COLOR_W-1:0] slots_o,
  output logic [SEL_W-1:0]             sel_led_o,
  output logic [CNT_W-1:0]             guess_count_o,
  output logic                         exhausted_o
);

  localparam int GW = NUM_SLOTS * COLOR_W;

  typedef enum logic [0:0] {
    ST_EDIT = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [GW-1:0]      slots_q, slots_d;
  logic [GW-1:0]      guess_q, guess_d;
  logic               valid_q, valid_d;
  logic [SEL_W-1:0]   sel_q,   sel_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               exh_q,   exh_d;

  // Colour step for one slot; up and down together cancel out.
  function automatic logic [COLOR_W-1:0] next_colour(
    input logic [COLOR_W-1:0] c,
    input logic               inc,
    input logic               dec
  );
    logic [COLOR_W-1:0] top;
    logic [COLOR_W-1:0] r;
    top = COLOR_W'(NUM_COLORS - 1);
    if (inc && !dec) begin
      if (c >= top) begin
        r = (WRAP != 0) ? {COLOR_W{1'b0}} : top;
      end else begin
        r = c + COLOR_W'(1);
      end
    end else if (dec && !inc) begin
      if (c == {COLOR_W{1'b0}}) begin
        r = (WRAP != 0) ? top : {COLOR_W{1'b0}};
      end else begin
        r = c - COLOR_W'(1);
      end
    end else begin
      r = c;
    end
    return r;
  endfunction

  // Slot selection step; wraps modulo NUM_SLOTS rather than 2**SEL_W.
  function automatic logic [SEL_W-1:0] next_sel(
    input logic [SEL_W-1:0] s,
    input logic             mv_left,
    input logic             mv_right
  );
    logic [SEL_W-1:0] r;
    if (mv_right && !mv_left) begin
      if (s >= SEL_W'(NUM_SLOTS - 1)) begin
        r = {SEL_W{1'b0}};
      end else begin
        r = s + SEL_W'(1);
      end
    end else if (mv_left && !mv_right) begin
      if (s == {SEL_W{1'b0}}) begin
        r = SEL_W'(NUM_SLOTS - 1);
      end else begin
        r = s - SEL_W'(1);
      end
    end else begin
      r = s;
    end
    return r;
  endfunction

  // Next-state logic: editing, snapshot on submit, hand-off on accept.
  always_comb begin
    state_d = state_q;
    slots_d = slots_q;
    guess_d = guess_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_EDIT: begin
        if (enable_i && submit_i && !exh_q) begin
          // Snapshot is the pre-edit slot value; same-cycle edits are dropped.
          guess_d = slots_q;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else if (enable_i && clear_i) begin
          slots_d = {GW{1'b0}};
          sel_d   = {SEL_W{1'b0}};
        end else if (enable_i) begin
          // Colour change targets the slot selected before this cycle's move.
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (sel_q == SEL_W'(i)) begin
              slots_d[i*COLOR_W +: COLOR_W] =
                next_colour(slots_q[i*COLOR_W +: COLOR_W], up_i, down_i);
            end else begin
              slots_d[i*COLOR_W +: COLOR_W] = slots_q[i*COLOR_W +: COLOR_W];
            end
          end
          sel_d = next_sel(sel_q, left_i, right_i);
        end else begin
          state_d = ST_EDIT;
        end
      end

      ST_HOLD: begin
        // Guess is frozen; only the scorer's ready is honoured here.
        if (valid_q && gbus.ready) begin
          valid_d = 1'b0;
          sel_d   = {SEL_W{1'b0}};
          state_d = ST_EDIT;
          if (cnt_q != CNT_W'(MAX_GUESSES)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
          if (CLEAR_ON_ACCEPT != 0) begin
            slots_d = {GW{1'b0}};
          end else begin
            slots_d = slots_q;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end

      default: begin
        state_d = ST_EDIT;
        valid_d = 1'b0;
      end
    endcase

    // Registered alongside the counter so it always matches guess_count.
    exh_d = (cnt_d == CNT_W'(MAX_GUESSES));
  end

  // State register with asynchronous reset; a reset in HOLD drops the guess.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EDIT;
      slots_q <= {GW{1'b0}};
      guess_q <= {GW{1'b0}};
      valid_q <= 1'b0;
      sel_q   <= {SEL_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      exh_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slots_q <= slots_d;
      guess_q <= guess_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      exh_q   <= exh_d;
    end
  end

  assign gbus.valid    = valid_q;
  assign gbus.data     = guess_q;
  assign slots_o       = slots_q;
  assign sel_led_o     = sel_q;
  assign guess_count_o = cnt_q;
  assign exhausted_o   = exh_q;

endmodule
